// File: rtl/adder_checker_if.sv
// Stimulus/response bundle between the full-adder under test and its checker.
// The master drives operands and the adder result; the checker only observes.
interface adder_checker_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output a, b, cin, sum, cout);
  modport slave  (input  a, b, cin, sum, cout);
endinterface

// File: rtl/adder_checker.sv
// Full-adder response checker: waits SETTLE_CYC stable clocks after a vector change, then checks once.
// chk_pulse rises SETTLE_CYC+1 clocks after the change is applied; there is no backpressure and it never stalls the stimulus.
module adder_checker #(
  parameter int WIDTH      = 1,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  adder_checker_if.slave       vec_if,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 err,
  output logic [2*WIDTH:0]     err_vec,
  output logic [7:0]           cov_mask,
  output logic                 done,
  output logic                 chk_pulse
);
  localparam int VW = 2 * WIDTH + 1;
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [VW-1:0]    last_vec_q;
  logic [VW-1:0]    cur_vec;
  logic             change;
  logic [WIDTH:0]   golden;
  logic             mismatch;
  logic [2:0]       cov_idx;
  logic             do_check;

  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
  logic             err_q, done_q;
  logic [VW-1:0]    err_vec_q;
  logic [7:0]       cov_mask_q;

  assign cur_vec = {vec_if.a, vec_if.b, vec_if.cin};
  assign change  = (cur_vec != last_vec_q);
  assign cov_idx = {vec_if.a[0], vec_if.b[0], vec_if.cin};
  assign golden  = {1'b0, vec_if.a} + {1'b0, vec_if.b} + {{WIDTH{1'b0}}, vec_if.cin};

  // Four-state compare so an X/Z on the adder outputs is scored as a failure.
  always_comb begin
    mismatch = ({vec_if.cout, vec_if.sum} !== golden);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_check = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          cnt_d   = RELOAD;
        end
        S_SETTLE: begin
          if (change)            cnt_d   = RELOAD;
          else if (cnt_q == '0)  state_d = S_CHECK;
          else                   cnt_d   = cnt_q - 8'd1;
        end
        S_CHECK: begin
          do_check = 1'b1;
          // A change landing on the check cycle starts the next settle directly.
          if (change) begin
            state_d = S_SETTLE;
            cnt_d   = RELOAD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (change) begin
            state_d = S_SETTLE;
            cnt_d   = RELOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_vec_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (en) last_vec_q <= cur_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      err_vec_q  <= '0;
      cov_mask_q <= '0;
      done_q     <= 1'b0;
    end else begin
      if (do_check) begin
        if (!mismatch) begin
          if (pass_cnt_q != CNT_MAX) pass_cnt_q <= pass_cnt_q + 1'b1;
        end else begin
          if (fail_cnt_q != CNT_MAX) fail_cnt_q <= fail_cnt_q + 1'b1;
          if (!err_q) err_vec_q <= cur_vec;
          err_q <= 1'b1;
        end
        cov_mask_q[cov_idx] <= 1'b1;
      end
      if (cov_mask_q == 8'hFF) done_q <= 1'b1;
    end
  end

  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign err       = err_q;
  assign err_vec   = err_vec_q;
  assign cov_mask  = cov_mask_q;
  assign done      = done_q;
  assign chk_pulse = do_check;
endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker: a behavioural adder with selectable faults feeds the checker;
// stimulus pushes expected results per held vector, a monitor pops them on chk_pulse.
module tb_adder_checker;
  localparam int WIDTH      = 1;
  localparam int SETTLE_CYC = 4;
  localparam int CNT_W      = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  always #5 clk = ~clk;

  adder_checker_if #(.WIDTH(WIDTH)) ifc ();

  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic             err, done, chk_pulse;
  logic [2*WIDTH:0] err_vec;
  logic [7:0]       cov_mask;

  adder_checker #(.WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .vec_if    (ifc.slave),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .err       (err),
    .err_vec   (err_vec),
    .cov_mask  (cov_mask),
    .done      (done),
    .chk_pulse (chk_pulse)
  );

  // 0: correct adder, 1: cout stuck at 0, 2: sum inverted
  int fault_mode = 0;
  logic [WIDTH:0] adder_res;
  always_comb begin
    adder_res = {1'b0, ifc.a} + {1'b0, ifc.b} + {{WIDTH{1'b0}}, ifc.cin};
    if (fault_mode == 1)      adder_res[WIDTH] = 1'b0;
    else if (fault_mode == 2) adder_res[WIDTH-1:0] = ~adder_res[WIDTH-1:0];
  end
  assign ifc.sum  = adder_res[WIDTH-1:0];
  assign ifc.cout = adder_res[WIDTH];

  typedef struct {
    logic [2:0] vec;
    int         exp_pass;
    int         exp_fail;
    int         apply_cyc;
    bit         chk_lat;
  } item_t;

  item_t      sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         pulses = 0;
  int         mp     = 0;
  int         mf     = 0;
  logic [7:0] fail_tab = 8'h00;   // bit v set: vector v is expected to mismatch

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pass_cnt"}, 32'(pass_cnt), 0);
    check({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_err_vec"}, 32'(err_vec), 0);
    check({tag, "_cov_mask"}, 32'(cov_mask), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_chk_pulse"}, 32'(chk_pulse), 0);
  endtask

  task automatic flush_sb(input string tag);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_missing_checks: got %0d unchecked vectors expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mp     = 0;
    mf     = 0;
    pulses = 0;
  endtask

  // Drive vector v just after a rising edge and hold it for 'hold' clocks.
  task automatic apply(input logic [2:0] v, input int hold, input bit expect_chk, input bit lat);
    item_t it;
    @(posedge clk);
    #1;
    {ifc.a, ifc.b, ifc.cin} = v;
    if (expect_chk) begin
      if (fail_tab[v]) begin
        if (mf < 255) mf++;
      end else begin
        if (mp < 255) mp++;
      end
      it.vec = v; it.exp_pass = mp; it.exp_fail = mf; it.apply_cyc = cyc; it.chk_lat = lat;
      sb.push_back(it);
    end
    repeat (hold - 1) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    item_t it;
    int    lat;
    forever begin
      @(negedge clk);
      if (rst_n && chk_pulse) begin
        pulses++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chk_pulse: got pulse for vec %0b expected none (t=%0t)",
                   {ifc.a, ifc.b, ifc.cin}, $time);
        end else begin
          it = sb.pop_front();
          check("chk_vec", 32'({ifc.a, ifc.b, ifc.cin}), 32'(it.vec));
          if (it.chk_lat) begin
            lat = cyc - it.apply_cyc;
            checks++;
            if (lat < SETTLE_CYC || lat > SETTLE_CYC + 1) begin
              errors++;
              $display("FAIL chk_latency: got %0d clocks expected %0d..%0d", lat, SETTLE_CYC, SETTLE_CYC + 1);
            end
          end
          @(negedge clk);
          check("pass_cnt_after_chk", 32'(pass_cnt), 32'(it.exp_pass));
          check("fail_cnt_after_chk", 32'(fail_cnt), 32'(it.exp_fail));
        end
      end
    end
  end

  initial begin : stimulus
    {ifc.a, ifc.b, ifc.cin} = 3'b000;
    #2;

    // Correct adder, all eight vectors
    fault_mode = 0; fail_tab = 8'h00;
    do_reset();
    en = 1'b1;
    for (int v = 0; v < 8; v++) apply(3'(v), 100, 1'b1, 1'b0);
    check("A_pass_cnt", 32'(pass_cnt), 8);
    check("A_fail_cnt", 32'(fail_cnt), 0);
    check("A_err", 32'(err), 0);
    check("A_cov_mask", 32'(cov_mask), 32'hFF);
    check("A_done", 32'(done), 1);
    check("A_pulses", 32'(pulses), 8);
    flush_sb("A");

    // cout stuck at 0: vectors 011, 101, 110, 111 fail
    fault_mode = 1; fail_tab = 8'b1110_1000;
    do_reset();
    en = 1'b1;
    for (int v = 0; v < 8; v++) apply(3'(v), 100, 1'b1, 1'b0);
    check("B_pass_cnt", 32'(pass_cnt), 4);
    check("B_fail_cnt", 32'(fail_cnt), 4);
    check("B_err", 32'(err), 1);
    check("B_err_vec", 32'(err_vec), 32'b011);
    check("B_cov_mask", 32'(cov_mask), 32'hFF);
    flush_sb("B");

    // Vector changing every 2 clocks never settles; then one long hold checks once
    fault_mode = 0; fail_tab = 8'h00;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 20; i++) apply(3'(i % 8), 2, 1'b0, 1'b0);
    check("C_pulses_fast", 32'(pulses), 0);
    check("C_pass_fast", 32'(pass_cnt), 0);
    apply(3'b110, 10, 1'b1, 1'b1);
    check("C_pulses_hold", 32'(pulses), 1);
    check("C_pass_hold", 32'(pass_cnt), 1);
    flush_sb("C");

    // en low for the upper half of the vectors
    do_reset();
    en = 1'b1;
    for (int v = 0; v < 4; v++) apply(3'(v), 100, 1'b1, 1'b0);
    en = 1'b0;
    for (int v = 4; v < 8; v++) apply(3'(v), 100, 1'b0, 1'b0);
    check("D_pass_cnt", 32'(pass_cnt), 4);
    check("D_cov_mask", 32'(cov_mask), 32'h0F);
    check("D_done", 32'(done), 0);
    flush_sb("D");

    // 300 failing vectors saturate the fail counter
    fault_mode = 2; fail_tab = 8'hFF;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 300; i++) apply(3'(i % 8), 8, 1'b1, 1'b0);
    check("E_fail_sat", 32'(fail_cnt), 255);
    check("E_pass_cnt", 32'(pass_cnt), 0);
    check("E_err_vec", 32'(err_vec), 32'b000);
    flush_sb("E");

    // Asynchronous reset in the middle of a settle window
    fault_mode = 0; fail_tab = 8'h00;
    do_reset();
    en = 1'b1;
    for (int v = 0; v < 5; v++) apply(3'(v), 20, 1'b1, 1'b0);
    check("F_pass_before", 32'(pass_cnt), 5);
    apply(3'b101, 2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("F_midsettle");
    mp = 0;
    mf = 0;
    #10;
    rst_n = 1'b1;
    apply(3'b111, 10, 1'b1, 1'b0);
    check("F_pass_after", 32'(pass_cnt), 1);
    check("F_fail_after", 32'(fail_cnt), 0);
    flush_sb("F");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
